// File: rtl/clock_display_scanner.sv
// Six-digit multiplexed 7-segment scanner for the alarm clock core.
// Latches one coherent time snapshot per frame, scans digits and flashes while the alarm is active.
module clock_display_scanner #(
   parameter int SCAN_DIV     = 4,
   parameter int BLINK_DIV    = 8,
   parameter int COMMON_ANODE = 0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] houin1,
   input  logic [3:0] houin0,
   input  logic [3:0] minin1,
   input  logic [3:0] minin0,
   input  logic [3:0] secin1,
   input  logic [3:0] secin0,
   input  logic       alarm,
   input  logic       blank_lz,
   output logic [6:0] seg,
   output logic       dp,
   output logic [5:0] digsel,
   output logic       frame_start
);

   localparam int   PW  = $clog2(SCAN_DIV);
   localparam int   BW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic INV = (COMMON_ANODE != 0);

   logic [PW-1:0] r_presc;
   logic [2:0]    r_idx;
   logic [3:0]    r_sh_h1, r_sh_h0, r_sh_m1, r_sh_m0, r_sh_s1, r_sh_s0;
   logic          r_sh_alarm;
   logic [BW-1:0] r_blink_cnt;
   logic          r_phase;
   logic [6:0]    r_seg;
   logic          r_dp;
   logic [5:0]    r_digsel;
   logic          r_frame_start;

   logic          w_wrap;
   logic          w_frame_edge;
   logic [3:0]    w_digit;
   logic [6:0]    w_seg;
   logic          w_dp;
   logic [5:0]    w_digsel;

   assign w_wrap       = (r_presc == PW'(SCAN_DIV - 1));
   assign w_frame_edge = w_wrap && (r_idx == 3'd5);

   always_comb begin
      w_digit = r_sh_s0;
      case (r_idx)
         3'd1:    w_digit = r_sh_s1;
         3'd2:    w_digit = r_sh_m0;
         3'd3:    w_digit = r_sh_m1;
         3'd4:    w_digit = r_sh_h0;
         3'd5:    w_digit = r_sh_h1;
         default: w_digit = r_sh_s0;
      endcase

      case (w_digit)
         4'd0:    w_seg = 7'h3F;
         4'd1:    w_seg = 7'h06;
         4'd2:    w_seg = 7'h5B;
         4'd3:    w_seg = 7'h4F;
         4'd4:    w_seg = 7'h66;
         4'd5:    w_seg = 7'h6D;
         4'd6:    w_seg = 7'h7D;
         4'd7:    w_seg = 7'h07;
         4'd8:    w_seg = 7'h7F;
         4'd9:    w_seg = 7'h6F;
         default: w_seg = 7'h40;
      endcase

      w_dp     = (r_idx == 3'd2) || (r_idx == 3'd4);
      w_digsel = 6'b000001 << r_idx;

      if (blank_lz && (r_idx == 3'd5) && (r_sh_h1 == 4'd0))
         w_seg = '0;

      // Blink blanks segments and separators but keeps digsel scanning.
      if (r_sh_alarm && r_phase) begin
         w_seg = '0;
         w_dp  = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_presc       <= '0;
         r_idx         <= '0;
         r_sh_h1       <= '0;
         r_sh_h0       <= '0;
         r_sh_m1       <= '0;
         r_sh_m0       <= '0;
         r_sh_s1       <= '0;
         r_sh_s0       <= '0;
         r_sh_alarm    <= 1'b0;
         r_blink_cnt   <= '0;
         r_phase       <= 1'b0;
         r_seg         <= {7{INV}};
         r_dp          <= INV;
         r_digsel      <= {6{INV}};
         r_frame_start <= 1'b0;
      end else begin
         r_presc <= w_wrap ? '0 : r_presc + 1'b1;
         if (w_wrap)
            r_idx <= (r_idx == 3'd5) ? '0 : r_idx + 3'd1;

         r_frame_start <= w_frame_edge;

         if (w_frame_edge) begin
            r_sh_h1    <= {2'b00, houin1};
            r_sh_h0    <= houin0;
            r_sh_m1    <= minin1;
            r_sh_m0    <= minin0;
            r_sh_s1    <= secin1;
            r_sh_s0    <= secin0;
            r_sh_alarm <= alarm;
         end

         // Counter advances on the shadow flag in force before the snapshot,
         // so a fresh alarm shows BLINK_DIV lit frames before the first blank one.
         if (!r_sh_alarm) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
         end else if (w_frame_edge) begin
            if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
               r_blink_cnt <= '0;
               r_phase     <= ~r_phase;
            end else begin
               r_blink_cnt <= r_blink_cnt + 1'b1;
            end
         end

         r_seg    <= w_seg ^ {7{INV}};
         r_dp     <= w_dp ^ INV;
         r_digsel <= w_digsel ^ {6{INV}};
      end
   end

   assign seg         = r_seg;
   assign dp          = r_dp;
   assign digsel      = r_digsel;
   assign frame_start = r_frame_start;

endmodule
